// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 4-bit computer, plus the program-load mode.
// Latency: 3 clocks per instruction (FETCH, DECODE, EXEC); strobes are combinational from state/IR/flags.
// Backpressure: none; START/STOP/PRGM are sampled only in HALT/EXEC/PROG and the datapath is never stalled.
module control_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              PRGM,
    input  logic              PRGM_WR,
    input  logic [ADDR_W-1:0] PRGM_ADDR,
    input  logic [DATA_W-1:0] INSTR,
    input  logic              ZERO,
    input  logic              CARRY,
    output logic              PC_EN,
    output logic              PC_WE,
    output logic              PC_PRGM,
    output logic [ADDR_W-1:0] PC_IN,
    output logic              ADDR_SEL,
    output logic              MEM_RD,
    output logic              MEM_WE,
    output logic              ACC_LD,
    output logic              FLAG_LD,
    output logic [1:0]        ALU_OP,
    output logic              OUT_LD,
    output logic              HALTED,
    output logic              ILLEGAL
);

    localparam logic [2:0] ST_HALT   = 3'd0;
    localparam logic [2:0] ST_PROG   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_IMM  = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DATA_W-1:0] ir;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_HALT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                ir <= INSTR;
            end
        end
    end

    // PROG exits through its own PRGM=0 cycle, which is the PC rewind cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT: begin
                if (PRGM)       state_nxt = ST_PROG;
                else if (START) state_nxt = ST_FETCH;
            end
            ST_PROG: begin
                if (!PRGM) state_nxt = ST_HALT;
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (opcode == 4'hF || STOP) state_nxt = ST_HALT;
                else                        state_nxt = ST_FETCH;
            end
            default:   state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        PC_EN    = 1'b0;
        PC_WE    = 1'b0;
        PC_PRGM  = 1'b0;
        PC_IN    = '0;
        ADDR_SEL = 1'b0;
        MEM_RD   = 1'b0;
        MEM_WE   = 1'b0;
        ACC_LD   = 1'b0;
        FLAG_LD  = 1'b0;
        ALU_OP   = ALU_PASS;
        OUT_LD   = 1'b0;
        HALTED   = 1'b0;
        ILLEGAL  = 1'b0;
        case (state)
            ST_HALT: HALTED = 1'b1;
            ST_PROG: begin
                if (PRGM) begin
                    PC_PRGM = 1'b1;
                    PC_IN   = PRGM_ADDR;
                    MEM_WE  = PRGM_WR;
                end else begin
                    PC_WE = 1'b1;
                end
            end
            ST_FETCH: begin
                MEM_RD = 1'b1;
                PC_EN  = 1'b1;
            end
            ST_EXEC: begin
                case (opcode)
                    4'h0: ;
                    4'h1: begin
                        MEM_RD   = 1'b1;
                        ADDR_SEL = 1'b1;
                        ACC_LD   = 1'b1;
                        ALU_OP   = ALU_PASS;
                    end
                    4'h2, 4'h3: begin
                        MEM_RD   = 1'b1;
                        ADDR_SEL = 1'b1;
                        ACC_LD   = 1'b1;
                        FLAG_LD  = 1'b1;
                        ALU_OP   = (opcode == 4'h2) ? ALU_ADD : ALU_SUB;
                    end
                    4'h4: begin
                        MEM_WE   = 1'b1;
                        ADDR_SEL = 1'b1;
                    end
                    4'h5: begin
                        ACC_LD = 1'b1;
                        ALU_OP = ALU_IMM;
                    end
                    4'h6, 4'h7, 4'h8: begin
                        if (opcode == 4'h6 || (opcode == 4'h7 && ZERO) || (opcode == 4'h8 && CARRY)) begin
                            PC_WE = 1'b1;
                            PC_IN = operand;
                        end
                    end
                    4'hE: OUT_LD = 1'b1;
                    4'hF: ;
                    default: ILLEGAL = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each cycle's strobes, ALU_OP and PC_IN against hand-computed values.
module tb_control_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N, START, STOP, PRGM, PRGM_WR, ZERO, CARRY;
    logic [3:0] PRGM_ADDR;
    logic [7:0] INSTR;
    logic       PC_EN, PC_WE, PC_PRGM, ADDR_SEL, MEM_RD, MEM_WE, ACC_LD, FLAG_LD, OUT_LD, HALTED, ILLEGAL;
    logic [3:0] PC_IN;
    logic [1:0] ALU_OP;
    logic [10:0] strb;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] S_NONE    = 11'd0;
    localparam logic [10:0] S_PCEN    = 11'b100_0000_0000;
    localparam logic [10:0] S_PCWE    = 11'b010_0000_0000;
    localparam logic [10:0] S_PCPRGM  = 11'b001_0000_0000;
    localparam logic [10:0] S_ADDRSEL = 11'b000_1000_0000;
    localparam logic [10:0] S_MEMRD   = 11'b000_0100_0000;
    localparam logic [10:0] S_MEMWE   = 11'b000_0010_0000;
    localparam logic [10:0] S_ACCLD   = 11'b000_0001_0000;
    localparam logic [10:0] S_FLAGLD  = 11'b000_0000_1000;
    localparam logic [10:0] S_OUTLD   = 11'b000_0000_0100;
    localparam logic [10:0] S_HALTED  = 11'b000_0000_0010;
    localparam logic [10:0] S_ILLEGAL = 11'b000_0000_0001;
    localparam logic [10:0] S_FETCH   = S_MEMRD | S_PCEN;

    control_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP), .PRGM(PRGM),
        .PRGM_WR(PRGM_WR), .PRGM_ADDR(PRGM_ADDR), .INSTR(INSTR), .ZERO(ZERO), .CARRY(CARRY),
        .PC_EN(PC_EN), .PC_WE(PC_WE), .PC_PRGM(PC_PRGM), .PC_IN(PC_IN), .ADDR_SEL(ADDR_SEL),
        .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .ACC_LD(ACC_LD), .FLAG_LD(FLAG_LD), .ALU_OP(ALU_OP),
        .OUT_LD(OUT_LD), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
    );

    assign strb = {PC_EN, PC_WE, PC_PRGM, ADDR_SEL, MEM_RD, MEM_WE, ACC_LD, FLAG_LD, OUT_LD, HALTED, ILLEGAL};

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input logic [10:0] s, input logic [1:0] a, input logic [3:0] p);
        check({tag, ".strb"},  32'(strb),   32'(s));
        check({tag, ".alu"},   32'(ALU_OP), 32'(a));
        check({tag, ".pc_in"}, 32'(PC_IN),  32'(p));
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge of that cycle.
    task automatic cyc(input string tag, input logic [10:0] s, input logic [1:0] a, input logic [3:0] p);
        @(negedge CLK);
        check_outs(tag, s, a, p);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [7:0] ins,
                             input logic [10:0] s, input logic [1:0] a, input logic [3:0] p);
        INSTR = ins;
        cyc({tag, ".fetch"},  S_FETCH, 2'b00, 4'h0);
        cyc({tag, ".decode"}, S_NONE,  2'b00, 4'h0);
        cyc({tag, ".exec"},   s, a, p);
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; STOP = 1'b0; PRGM = 1'b0; PRGM_WR = 1'b0;
        ZERO = 1'b0; CARRY = 1'b0; PRGM_ADDR = 4'h0; INSTR = 8'h00;
        #2;
        check_outs("reset", S_HALTED, 2'b00, 4'h0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Program-load write then rewind.
        PRGM = 1'b1; PRGM_ADDR = 4'h3; PRGM_WR = 1'b1;
        cyc("halt_prgm", S_HALTED, 2'b00, 4'h0);
        cyc("prog_wr", S_PCPRGM | S_MEMWE, 2'b00, 4'h3);
        PRGM_WR = 1'b0; PRGM_ADDR = 4'h5;
        cyc("prog_nowr", S_PCPRGM, 2'b00, 4'h5);
        PRGM = 1'b0;
        cyc("rewind", S_PCWE, 2'b00, 4'h0);
        cyc("prog_halt", S_HALTED, 2'b00, 4'h0);

        // Start and run the opcode set.
        START = 1'b1;
        cyc("halt_start", S_HALTED, 2'b00, 4'h0);
        START = 1'b0;
        run_instr("ldi", 8'h53, S_ACCLD, 2'b11, 4'h0);
        ZERO = 1'b1;
        run_instr("jz_t", 8'h79, S_PCWE, 2'b00, 4'h9);
        ZERO = 1'b0;
        run_instr("jz_n", 8'h79, S_NONE, 2'b00, 4'h0);
        CARRY = 1'b1;
        run_instr("jc_t", 8'h86, S_PCWE, 2'b00, 4'h6);
        CARRY = 1'b0;
        run_instr("jc_n", 8'h86, S_NONE, 2'b00, 4'h0);
        run_instr("jmp", 8'h6D, S_PCWE, 2'b00, 4'hD);
        run_instr("lda", 8'h1C, S_MEMRD | S_ADDRSEL | S_ACCLD, 2'b00, 4'h0);
        run_instr("add", 8'h2A, S_MEMRD | S_ADDRSEL | S_ACCLD | S_FLAGLD, 2'b01, 4'h0);
        run_instr("sub", 8'h35, S_MEMRD | S_ADDRSEL | S_ACCLD | S_FLAGLD, 2'b10, 4'h0);
        run_instr("sta", 8'h47, S_MEMWE | S_ADDRSEL, 2'b00, 4'h0);
        run_instr("out", 8'hE0, S_OUTLD, 2'b00, 4'h0);
        run_instr("illegal", 8'hB0, S_ILLEGAL, 2'b00, 4'h0);
        run_instr("hlt", 8'hF0, S_NONE, 2'b00, 4'h0);
        cyc("hlt_halted", S_HALTED, 2'b00, 4'h0);

        // STOP is honoured at the end of EXEC.
        START = 1'b1;
        cyc("resume", S_HALTED, 2'b00, 4'h0);
        START = 1'b0; STOP = 1'b1;
        run_instr("stop_nop", 8'h00, S_NONE, 2'b00, 4'h0);
        cyc("stop_halted", S_HALTED, 2'b00, 4'h0);
        STOP = 1'b0;

        // PRGM beats START in HALT.
        PRGM = 1'b1; START = 1'b1; PRGM_ADDR = 4'hC;
        cyc("prio_halt", S_HALTED, 2'b00, 4'h0);
        START = 1'b0;
        cyc("prio_prog", S_PCPRGM, 2'b00, 4'hC);
        PRGM = 1'b0;
        cyc("rewind2", S_PCWE, 2'b00, 4'h0);
        cyc("rewind2_halt", S_HALTED, 2'b00, 4'h0);

        // PRGM is ignored while running.
        START = 1'b1;
        cyc("run2", S_HALTED, 2'b00, 4'h0);
        START = 1'b0; PRGM = 1'b1;
        run_instr("prgm_ign", 8'hE0, S_OUTLD, 2'b00, 4'h0);
        PRGM = 1'b0;

        // Asynchronous reset during STA execution.
        INSTR = 8'h4A;
        cyc("sta2.fetch", S_FETCH, 2'b00, 4'h0);
        cyc("sta2.decode", S_NONE, 2'b00, 4'h0);
        @(negedge CLK);
        check_outs("sta2.exec", S_MEMWE | S_ADDRSEL, 2'b00, 4'h0);
        #2;
        RESET_N = 1'b0;
        #1;
        check_outs("async_rst", S_HALTED, 2'b00, 4'h0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        cyc("post_rst", S_HALTED, 2'b00, 4'h0);
        START = 1'b1;
        cyc("post_rst_start", S_HALTED, 2'b00, 4'h0);
        START = 1'b0;
        cyc("post_rst_fetch", S_FETCH, 2'b00, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
